// File: rtl/muldiv_seq.sv
// RV64M MUL/DIV sequencer: MUL* in MUL_LAT edges, DIV/REM via radix-2 restoring in K+2 edges, div corner cases in 1.
// One op at a time; result held until out_ready, in_ready low unless IDLE; flush kills in-flight work.
module muldiv_seq #(
    parameter int XLEN    = 64,
    parameter int MUL_LAT = 3,
    parameter int TAG_W   = 7
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [12:0]      in_type,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [2:0] {S_IDLE, S_MUL_WAIT, S_DIV_ITER, S_FIXUP, S_DONE} state_t;

    localparam logic [3:0] OP_MUL    = 4'd0;
    localparam logic [3:0] OP_MULH   = 4'd1;
    localparam logic [3:0] OP_MULHSU = 4'd2;
    localparam logic [3:0] OP_MULHU  = 4'd3;
    localparam logic [3:0] OP_DIV    = 4'd4;
    localparam logic [3:0] OP_REM    = 4'd6;
    localparam logic [3:0] OP_REMU   = 4'd7;
    localparam logic [3:0] OP_MULW   = 4'd8;
    localparam logic [3:0] OP_DIVW   = 4'd9;
    localparam logic [3:0] OP_REMW   = 4'd11;
    localparam logic [3:0] OP_REMUW  = 4'd12;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic op_is_w(input logic [3:0] c);
        return c >= OP_MULW;
    endfunction

    function automatic logic op_is_rem(input logic [3:0] c);
        return (c == OP_REM) || (c == OP_REMU) || (c == OP_REMW) || (c == OP_REMUW);
    endfunction

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   src1_q, src1_d, src2_q, src2_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [XLEN-1:0]   dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
    logic              negq_q, negq_d, negr_q, negr_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              valid_q, valid_d, busy_q, busy_d;

    // Lowest set bit wins; an all-zero type decodes as MUL.
    logic [3:0] in_code;
    always_comb begin
        in_code = OP_MUL;
        for (int i = 12; i >= 0; i--) begin
            if (in_type[i]) in_code = 4'(i);
        end
    end

    logic            in_w, in_sdiv, in_mul;
    logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_ext, spec_res;
    logic            a_neg, b_neg, div_zero, div_ovf;
    always_comb begin
        in_w    = op_is_w(in_code);
        in_sdiv = (in_code == OP_DIV) || (in_code == OP_REM) || (in_code == OP_DIVW) || (in_code == OP_REMW);
        in_mul  = (in_code <= OP_MULHU) || (in_code == OP_MULW);
        if (in_w) begin
            a_ext = in_sdiv ? sext32(in_src1[31:0]) : {{(XLEN-32){1'b0}}, in_src1[31:0]};
            b_ext = in_sdiv ? sext32(in_src2[31:0]) : {{(XLEN-32){1'b0}}, in_src2[31:0]};
            min_ext = sext32(32'h8000_0000);
        end else begin
            a_ext   = in_src1;
            b_ext   = in_src2;
            min_ext = {1'b1, {(XLEN-1){1'b0}}};
        end
        a_neg    = in_sdiv && a_ext[XLEN-1];
        b_neg    = in_sdiv && b_ext[XLEN-1];
        mag_a    = a_neg ? -a_ext : a_ext;
        mag_b    = b_neg ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        div_ovf  = in_sdiv && (a_ext == min_ext) && (b_ext == '1);
        // Remainder of a zero divide is the dividend, sign-extended from bit 31 for every W op.
        if (op_is_rem(in_code)) begin
            spec_res = div_zero ? (in_w ? sext32(in_src1[31:0]) : in_src1) : '0;
        end else begin
            spec_res = div_zero ? '1 : a_ext;
        end
    end

    // Operands come straight from the inputs when finishing in the accept cycle (MUL_LAT==1).
    logic [3:0]        m_code;
    logic [XLEN-1:0]   m_a, m_b, mul_res;
    logic [2*XLEN-1:0] m_ax, m_bx, prod;
    always_comb begin
        m_code = (state_q == S_IDLE) ? in_code : op_q;
        m_a    = (state_q == S_IDLE) ? in_src1 : src1_q;
        m_b    = (state_q == S_IDLE) ? in_src2 : src2_q;
        m_ax   = {{XLEN{((m_code == OP_MULH) || (m_code == OP_MULHSU)) && m_a[XLEN-1]}}, m_a};
        m_bx   = {{XLEN{(m_code == OP_MULH) && m_b[XLEN-1]}}, m_b};
        prod   = m_ax * m_bx;
        case (m_code)
            OP_MUL:                      mul_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: mul_res = prod[2*XLEN-1:XLEN];
            default:                     mul_res = sext32(prod[31:0]);
        endcase
    end

    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] fix_pre, fix_res;
    always_comb begin
        shifted = {rem_q, dvd_q[XLEN-1]};
        ge      = shifted >= {1'b0, dvs_q};
        diff    = shifted - {1'b0, dvs_q};
        if (op_is_rem(op_q)) fix_pre = negr_q ? -rem_q : rem_q;
        else                 fix_pre = negq_q ? -dvd_q : dvd_q;
        fix_res = op_is_w(op_q) ? sext32(fix_pre[31:0]) : fix_pre;
    end

    assign in_ready = (state_q == S_IDLE) && !flush;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        tag_d    = tag_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    op_d   = in_code;
                    src1_d = in_src1;
                    src2_d = in_src2;
                    tag_d  = in_tag;
                    if (in_mul) begin
                        if (MUL_LAT <= 1) begin
                            state_d  = S_DONE;
                            result_d = mul_res;
                        end else begin
                            state_d = S_MUL_WAIT;
                            cnt_d   = 8'(MUL_LAT - 1);
                        end
                    end else if (div_zero || div_ovf) begin
                        state_d  = S_DONE;
                        result_d = spec_res;
                    end else begin
                        // W dividends are left-aligned so every iteration consumes the MSB.
                        state_d = S_DIV_ITER;
                        cnt_d   = in_w ? 8'd32 : 8'd64;
                        dvd_d   = in_w ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
                        dvs_d   = mag_b;
                        rem_d   = '0;
                        negq_d  = a_neg ^ b_neg;
                        negr_d  = a_neg;
                    end
                end
            end
            S_MUL_WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d  = S_DONE;
                    result_d = mul_res;
                end
            end
            S_DIV_ITER: begin
                rem_d = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
                dvd_d = {dvd_q[XLEN-2:0], ge};
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = S_FIXUP;
            end
            S_FIXUP: begin
                result_d = fix_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
        valid_d = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            tag_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            tag_q    <= tag_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            rem_q    <= rem_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
        end
    end

    assign out_valid  = valid_q;
    assign busy       = busy_q;
    assign out_result = result_q;
    assign out_tag    = tag_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: latency, result, tag, hold and flush behaviour.
module tb_muldiv_seq;

    logic        clock = 1'b0;
    logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [12:0] in_type;
    logic [63:0] in_src1, in_src2, out_result;
    logic [6:0]  in_tag, out_tag;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [6:0]  tag_ctr = 7'd1;

    localparam logic [12:0] T_MUL    = 13'h0001;
    localparam logic [12:0] T_MULH   = 13'h0002;
    localparam logic [12:0] T_MULHSU = 13'h0004;
    localparam logic [12:0] T_MULHU  = 13'h0008;
    localparam logic [12:0] T_DIV    = 13'h0010;
    localparam logic [12:0] T_DIVU   = 13'h0020;
    localparam logic [12:0] T_REM    = 13'h0040;
    localparam logic [12:0] T_REMU   = 13'h0080;
    localparam logic [12:0] T_MULW   = 13'h0100;
    localparam logic [12:0] T_DIVW   = 13'h0200;
    localparam logic [12:0] T_DIVUW  = 13'h0400;
    localparam logic [12:0] T_REMW   = 13'h0800;
    localparam logic [12:0] T_REMUW  = 13'h1000;

    muldiv_seq #(.XLEN(64), .MUL_LAT(3), .TAG_W(7)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic chk_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [12:0] typ, input logic [63:0] a, input logic [63:0] b,
                         input logic [6:0] t);
        @(negedge clock);
        in_type  = typ;
        in_src1  = a;
        in_src2  = b;
        in_tag   = t;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    // Latency counts the accept edge as edge 1.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 300) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic drain(input string name);
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        chk_vec({name, "/idle"}, {62'd0, busy, out_valid}, 64'd0);
    endtask

    task automatic run_op(input string name, input logic [12:0] typ, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_res, input int exp_lat);
        int         lat;
        logic [6:0] t;
        t       = tag_ctr;
        tag_ctr = tag_ctr + 7'd1;
        issue(typ, a, b, t);
        wait_done(lat);
        chk_vec({name, "/lat"}, 64'(lat), 64'(exp_lat));
        chk_vec({name, "/res"}, out_result, exp_res);
        chk_vec({name, "/tag"}, 64'(out_tag), 64'(t));
        drain(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat;
        logic seen_valid;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_type   = '0;
        in_src1   = '0;
        in_src2   = '0;
        in_tag    = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk_vec("rst/out_valid", 64'(out_valid), 64'd0);
        chk_vec("rst/busy", 64'(busy), 64'd0);
        chk_vec("rst/result", out_result, 64'd0);
        chk_vec("rst/tag", 64'(out_tag), 64'd0);
        chk_vec("rst/in_ready", 64'(in_ready), 64'd1);

        run_op("mul",    T_MUL,    64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 3);
        run_op("mulh",   T_MULH,   64'h8000_0000_0000_0000, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        run_op("mulhu",  T_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 3);
        run_op("mulhsu", T_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        run_op("mulw",   T_MULW,   64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 3);
        run_op("multi",  13'h1011, 64'd3, 64'd5, 64'd15, 3);
        run_op("div",    T_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66);
        run_op("rem",    T_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("divu",   T_DIVU,   64'd100, 64'd7, 64'd14, 66);
        run_op("remu",   T_REMU,   64'd100, 64'd7, 64'd2, 66);
        run_op("divu0",  T_DIVU,   64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("rem0",   T_REM,    64'd7, 64'd0, 64'd7, 1);
        run_op("divovf", T_DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
        run_op("removf", T_REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        run_op("divuw",  T_DIVUW,  64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        run_op("divw",   T_DIVW,   64'd7, 64'h0000_0000_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 34);
        run_op("remw",   T_REMW,   64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        run_op("remuw0", T_REMUW,  64'h0000_0000_8000_0005, 64'd0, 64'hFFFF_FFFF_8000_0005, 1);

        // Result must hold while writeback stalls.
        issue(T_MUL, 64'd6, 64'd7, 7'h55);
        wait_done(lat);
        chk_vec("hold/lat", 64'(lat), 64'd3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            chk_vec("hold/res", out_result, 64'd42);
            chk_vec("hold/tag", 64'(out_tag), 64'h55);
            chk_vec("hold/vld_rdy", {62'd0, out_valid, in_ready}, 64'd2);
        end
        drain("hold");

        // Flush at DIV iteration 10 with a competing in_valid.
        issue(T_DIV, 64'd1000, 64'd3, 7'h22);
        repeat (9) @(posedge clock);
        @(negedge clock);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_type  = T_MUL;
        in_src1  = 64'd9;
        in_src2  = 64'd9;
        #1;
        chk_vec("flush/in_ready", 64'(in_ready), 64'd0);
        @(posedge clock);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_vec("flush/idle", {62'd0, busy, out_valid}, 64'd0);
        seen_valid = 1'b0;
        repeat (70) begin
            @(posedge clock);
            #1;
            seen_valid = seen_valid | out_valid | busy;
        end
        chk_vec("flush/quiet", 64'(seen_valid), 64'd0);
        run_op("postflush", T_DIV, 64'd1000, 64'd3, 64'd333, 66);

        // Flush beats a same-cycle out_ready in DONE.
        issue(T_MUL, 64'd3, 64'd5, 7'h11);
        wait_done(lat);
        @(negedge clock);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        chk_vec("flushdone/idle", {62'd0, busy, out_valid}, 64'd0);
        run_op("last", T_MUL, 64'd11, 64'd12, 64'd132, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
